// File: rtl/key_pkg.sv
// key_pkg
//   Shared types for the pushbutton conditioning path.
//   debounce_state_t : per-channel debounce FSM state, also exported from
//                      each channel so the level can be decoded from it
//                      and so checkers can observe it.
//   is_level()       : debounced active-high level of a channel state.
package key_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } debounce_state_t;

    // The key still counts as held while a release is being qualified.
    function automatic logic is_level(input debounce_state_t s);
        return (s == HELD) || (s == RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce
//   One pushbutton channel: 2-flop synchronizer, debounce FSM with a
//   stability counter, and registered one-cycle press/release pulses.
//   Ports:
//     clock        : system clock
//     reset_L      : asynchronous active-low reset
//     key_raw_L    : raw pushbutton, active-low (0 = pressed)
//     state        : current FSM state (debounced level is decoded from it)
//     key_pressed  : one-cycle pulse after an accepted press
//     key_released : one-cycle pulse after an accepted release
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
)
(
    input  logic            clock,
    input  logic            reset_L,
    input  logic            key_raw_L,
    output debounce_state_t state,
    output logic            key_pressed,
    output logic            key_released
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q;
    logic            s;
    debounce_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            press_evt, release_evt;

    // Sync flops reset to 1 so the channel starts out "released".
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_raw_L};
        end
    end

    assign s = ~sync_q[1];

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q      <= RELEASED;
            cnt_q        <= '0;
            key_pressed  <= 1'b0;
            key_released <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            key_pressed  <= press_evt;
            key_released <= release_evt;
        end
    end

    // The counter is cleared on every state change and stops advancing once
    // it reaches CNT_LAST, because that same sample moves the FSM on.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        press_evt   = 1'b0;
        release_evt = 1'b0;
        case (state_q)
            RELEASED: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = HELD;
                    cnt_d     = '0;
                    press_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = RELEASED;
                    cnt_d       = '0;
                    release_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner
//   Board-pin front end for the game core: debounces the active-low
//   pushbuttons and double-flop synchronizes the slide switches.
//   Ports:
//     clock        : system clock (CLOCK_50 domain)
//     reset_L      : asynchronous active-low reset
//     key_raw_L    : raw pushbuttons, active-low (0 = pressed)
//     sw_raw       : raw slide switches
//     key_level    : debounced key state, active-high (1 = held)
//     key_pressed  : one-cycle pulse per accepted press
//     key_released : one-cycle pulse per accepted release
//     sw_sync      : 2-flop synchronized switches (no debounce)
module key_conditioner
    import key_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int SW_WIDTH        = 18,
    parameter int DEBOUNCE_CYCLES = 500000
)
(
    input  logic                clock,
    input  logic                reset_L,
    input  logic [N_KEYS-1:0]   key_raw_L,
    input  logic [SW_WIDTH-1:0] sw_raw,
    output logic [N_KEYS-1:0]   key_level,
    output logic [N_KEYS-1:0]   key_pressed,
    output logic [N_KEYS-1:0]   key_released,
    output logic [SW_WIDTH-1:0] sw_sync
);

    logic [SW_WIDTH-1:0] sw_meta_q;

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            sw_meta_q <= '0;
            sw_sync   <= '0;
        end else begin
            sw_meta_q <= sw_raw;
            sw_sync   <= sw_meta_q;
        end
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        debounce_state_t key_state;

        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clock        (clock),
            .reset_L      (reset_L),
            .key_raw_L    (key_raw_L[i]),
            .state        (key_state),
            .key_pressed  (key_pressed[i]),
            .key_released (key_released[i])
        );

        assign key_level[i] = is_level(key_state);
    end

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

    localparam int N_KEYS   = 4;
    localparam int SW_WIDTH = 18;
    localparam int DC       = 4;

    logic                clock = 1'b0;
    logic                reset_L = 1'b1;
    logic [N_KEYS-1:0]   key_raw_L = '1;
    logic [SW_WIDTH-1:0] sw_raw = '0;
    logic [N_KEYS-1:0]   key_level;
    logic [N_KEYS-1:0]   key_pressed;
    logic [N_KEYS-1:0]   key_released;
    logic [SW_WIDTH-1:0] sw_sync;

    int total = 0;
    int bad   = 0;

    key_conditioner #(
        .N_KEYS          (N_KEYS),
        .SW_WIDTH        (SW_WIDTH),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clock        (clock),
        .reset_L      (reset_L),
        .key_raw_L    (key_raw_L),
        .sw_raw       (sw_raw),
        .key_level    (key_level),
        .key_pressed  (key_pressed),
        .key_released (key_released),
        .sw_sync      (sw_sync)
    );

    // clock / reset block
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // advance one active edge and sample 1 time unit later
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        key_raw_L = '1;
        for (int k = 0; k < n; k++) tick();
    endtask

    typedef struct {
        logic [N_KEYS-1:0]   key_raw_L;
        logic [SW_WIDTH-1:0] sw_raw;
        logic [N_KEYS-1:0]   level;
        logic [N_KEYS-1:0]   pressed;
        logic [N_KEYS-1:0]   released;
        logic [SW_WIDTH-1:0] sw_sync;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int first;
        int cnt;
        int rel_cnt;
        int hi_cnt;
        int rise;
        int fall;
        logic [N_KEYS-1:0] pat;

        // Clean press of key 3 and release, plus two switch words.
        // Entry i: inputs applied before edge i+1, outputs expected after it.
        vecs[0]  = '{4'b0111, 18'h2A5A5, 4'h0, 4'h0, 4'h0, 18'h00000};
        vecs[1]  = '{4'b0111, 18'h2A5A5, 4'h0, 4'h0, 4'h0, 18'h2A5A5};
        vecs[2]  = '{4'b0111, 18'h2A5A5, 4'h0, 4'h0, 4'h0, 18'h2A5A5};
        vecs[3]  = '{4'b0111, 18'h2A5A5, 4'h0, 4'h0, 4'h0, 18'h2A5A5};
        vecs[4]  = '{4'b0111, 18'h2A5A5, 4'h0, 4'h0, 4'h0, 18'h2A5A5};
        vecs[5]  = '{4'b0111, 18'h2A5A5, 4'h0, 4'h0, 4'h0, 18'h2A5A5};
        vecs[6]  = '{4'b0111, 18'h2A5A5, 4'h8, 4'h8, 4'h0, 18'h2A5A5};
        vecs[7]  = '{4'b0111, 18'h2A5A5, 4'h8, 4'h0, 4'h0, 18'h2A5A5};
        vecs[8]  = '{4'b1111, 18'h15A5A, 4'h8, 4'h0, 4'h0, 18'h2A5A5};
        vecs[9]  = '{4'b1111, 18'h15A5A, 4'h8, 4'h0, 4'h0, 18'h15A5A};
        vecs[10] = '{4'b1111, 18'h15A5A, 4'h8, 4'h0, 4'h0, 18'h15A5A};
        vecs[11] = '{4'b1111, 18'h15A5A, 4'h8, 4'h0, 4'h0, 18'h15A5A};
        vecs[12] = '{4'b1111, 18'h15A5A, 4'h8, 4'h0, 4'h0, 18'h15A5A};
        vecs[13] = '{4'b1111, 18'h15A5A, 4'h8, 4'h0, 4'h0, 18'h15A5A};
        vecs[14] = '{4'b1111, 18'h15A5A, 4'h0, 4'h0, 4'h8, 18'h15A5A};
        vecs[15] = '{4'b1111, 18'h15A5A, 4'h0, 4'h0, 4'h0, 18'h15A5A};

        // Power-on reset
        #2;
        reset_L = 1'b0;
        #1;
        check("por_level", 32'(key_level), 32'h0);
        check("por_pressed", 32'(key_pressed), 32'h0);
        check("por_released", 32'(key_released), 32'h0);
        check("por_sw_sync", 32'(sw_sync), 32'h0);
        tick();
        tick();
        reset_L = 1'b1;
        idle(2);

        // Table-driven clean press/release with switch synchronization
        for (int i = 0; i < 16; i++) begin
            key_raw_L = vecs[i].key_raw_L;
            sw_raw    = vecs[i].sw_raw;
            tick();
            check($sformatf("vec%0d_level", i), 32'(key_level), 32'(vecs[i].level));
            check($sformatf("vec%0d_pressed", i), 32'(key_pressed), 32'(vecs[i].pressed));
            check($sformatf("vec%0d_released", i), 32'(key_released), 32'(vecs[i].released));
            check($sformatf("vec%0d_sw_sync", i), 32'(sw_sync), 32'(vecs[i].sw_sync));
        end
        idle(4);

        // Bounce on key 0: low 3, high 2, low 3, then high
        cnt = 0; rel_cnt = 0; hi_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            key_raw_L = '1;
            key_raw_L[0] = (c < 3 || (c >= 5 && c < 8)) ? 1'b0 : 1'b1;
            tick();
            if (key_pressed[0])  cnt++;
            if (key_released[0]) rel_cnt++;
            if (key_level[0])    hi_cnt++;
        end
        check("bounce_pressed", 32'(cnt), 32'd0);
        check("bounce_released", 32'(rel_cnt), 32'd0);
        check("bounce_level", 32'(hi_cnt), 32'd0);

        // Key 1 held for 100 cycles: one press, level 7..106
        cnt = 0; rel_cnt = 0; hi_cnt = 0; first = -1; rise = -1; fall = -1;
        for (int e = 1; e <= 115; e++) begin
            key_raw_L = '1;
            key_raw_L[1] = (e <= 100) ? 1'b0 : 1'b1;
            tick();
            if (key_pressed[1]) begin
                cnt++;
                if (first < 0) first = e;
            end
            if (key_released[1]) rel_cnt++;
            if (key_level[1]) begin
                hi_cnt++;
                if (rise < 0) rise = e;
            end else if (rise >= 0 && fall < 0) begin
                fall = e;
            end
        end
        check("hold_press_count", 32'(cnt), 32'd1);
        check("hold_press_edge", 32'(first), 32'd7);
        check("hold_level_rise", 32'(rise), 32'd7);
        check("hold_level_fall", 32'(fall), 32'd107);
        check("hold_level_cycles", 32'(hi_cnt), 32'd100);
        check("hold_release_count", 32'(rel_cnt), 32'd1);
        idle(4);

        // Keys 0 and 3 pressed together
        first = -1; pat = '0;
        for (int e = 1; e <= 10; e++) begin
            key_raw_L = 4'b0110;
            tick();
            if (key_pressed != '0 && first < 0) begin
                first = e;
                pat = key_pressed;
            end
        end
        check("simul_edge", 32'(first), 32'd7);
        check("simul_pattern", 32'(pat), 32'h9);
        check("simul_level", 32'(key_level), 32'h9);
        idle(12);
        check("simul_idle_level", 32'(key_level), 32'h0);

        // Reset while key 2 is held
        sw_raw = 18'h3FFFF;
        for (int e = 1; e <= 10; e++) begin
            key_raw_L = 4'b1011;
            tick();
        end
        check("pre_reset_level", 32'(key_level), 32'h4);
        check("pre_reset_sw_sync", 32'(sw_sync), 32'h3FFFF);
        #3;
        reset_L = 1'b0;
        #1;
        check("async_reset_level", 32'(key_level), 32'h0);
        check("async_reset_pressed", 32'(key_pressed), 32'h0);
        check("async_reset_released", 32'(key_released), 32'h0);
        check("async_reset_sw_sync", 32'(sw_sync), 32'h0);
        rel_cnt = 0;
        for (int e = 0; e < 3; e++) begin
            tick();
            if (key_released[2]) rel_cnt++;
        end
        reset_L = 1'b1;
        first = -1; cnt = 0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (key_released[2]) rel_cnt++;
            if (key_pressed[2]) begin
                cnt++;
                if (first < 0) first = e;
            end
        end
        check("reset_no_release", 32'(rel_cnt), 32'd0);
        check("reset_repress_edge", 32'(first), 32'd7);
        check("reset_repress_count", 32'(cnt), 32'd1);
        idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
